// File: rtl/frame_egress_unpack_if.sv
// Bundle between a port's output cell queue, the egress unpacker and the TX MAC
// byte/descriptor FIFO pair.
//   o_cell_ptr_*  : cell pointer FIFO {4'b0, portmap[3:0], 1'b0, ncells[6:0]}
//   o_cell_data_* : 128-bit cell FIFO, byte 0 at [127:120]
//   tx_data_*     : payload byte FIFO (afull = at least 16 entries still free)
//   tx_ptr_*      : descriptor FIFO {1'b0, portmap[3:0], plen[10:0]}
//   err_drop      : one-cycle pulse per discarded frame
// master = unpacker side, slave = queue/FIFO side.
interface frame_egress_unpack_if;
    localparam int unsigned PTR_W  = 16;
    localparam int unsigned CELL_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DESC_W = 16;

    logic [PTR_W-1:0]  o_cell_ptr_dout;
    logic              o_cell_ptr_empty;
    logic              o_cell_ptr_rd;
    logic [CELL_W-1:0] o_cell_data_dout;
    logic              o_cell_data_rd;
    logic [BYTE_W-1:0] tx_data_din;
    logic              tx_data_wr;
    logic              tx_data_afull;
    logic [DESC_W-1:0] tx_ptr_din;
    logic              tx_ptr_wr;
    logic              tx_ptr_full;
    logic              err_drop;

    modport master (
        input  o_cell_ptr_dout, o_cell_ptr_empty, o_cell_data_dout,
               tx_data_afull, tx_ptr_full,
        output o_cell_ptr_rd, o_cell_data_rd, tx_data_din, tx_data_wr,
               tx_ptr_din, tx_ptr_wr, err_drop
    );

    modport slave (
        output o_cell_ptr_dout, o_cell_ptr_empty, o_cell_data_dout,
               tx_data_afull, tx_ptr_full,
        input  o_cell_ptr_rd, o_cell_data_rd, tx_data_din, tx_data_wr,
               tx_ptr_din, tx_ptr_wr, err_drop
    );
endinterface

// File: rtl/frame_egress_unpack.sv
// Egress frame unpacker: pulls a cell pointer and its 128-bit cells from a port
// output queue, validates and strips the 2-byte length header, streams payload
// bytes into the TX byte FIFO and then writes one {portmap, plen} descriptor.
// Frames with a bad header are read out and discarded with an err_drop pulse.
// Ports:
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   bus   : frame_egress_unpack_if.master (cell queue in, TX FIFOs out)
module frame_egress_unpack #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic                   clk,
    input  logic                   rstn,
    frame_egress_unpack_if.master  bus
);
    localparam int unsigned LEN_W  = 11;
    localparam int unsigned NC_W   = 7;
    localparam int unsigned LANE_W = 5;
    localparam int unsigned CELL_W = 128;

    typedef struct packed {
        logic              rsvd;
        logic [3:0]        portmap;
        logic [LEN_W-1:0]  plen;
    } tx_desc_t;

    typedef enum logic [2:0] {
        IDLE, PTR_RD, PTR_CAP, CELL_RD, CELL_CAP, EMIT, DESC, DISCARD
    } state_t;

    state_t              state;
    logic [3:0]          portmap;
    logic [NC_W-1:0]     ncells;
    logic [LEN_W-1:0]    plen;
    logic [CELL_W-1:0]   word;
    logic [LANE_W-1:0]   lane;        // next lane to emit; bit 4 set = cell exhausted
    logic [LEN_W-1:0]    byte_cnt;
    logic [NC_W-1:0]     cell_cnt;    // cells left to drain while discarding
    logic                first_cell;
    logic                ptr_pend;    // pointer word not yet captured
    logic                disc_rd;

    // Header decode straight off the cell FIFO output in CELL_CAP
    logic [LEN_W-1:0]    hdr_len;
    logic [LEN_W-1:0]    hdr_plen;
    logic [NC_W:0]       hdr_cells;
    logic                hdr_ok;
    logic [3:0]          start_lane;
    logic                unused_ptr_bits;

    assign unused_ptr_bits = ^{bus.o_cell_ptr_dout[15:12], bus.o_cell_ptr_dout[7]};

    always_comb begin
        hdr_len    = {bus.o_cell_data_dout[122:120], bus.o_cell_data_dout[119:112]};
        hdr_plen   = hdr_len - LEN_W'(2);
        // 8-bit sum so a length of 2047 cannot wrap to zero cells
        hdr_cells  = {1'b0, hdr_len[10:4]} + (NC_W+1)'(|hdr_len[3:0]);
        hdr_ok     = (ncells != '0)
                  && ({1'b0, ncells} == hdr_cells)
                  && (hdr_plen >= LEN_W'(MIN_LEN))
                  && (hdr_plen <= LEN_W'(MAX_LEN));
        start_lane = first_cell ? 4'd2 : 4'd0;
    end

    // Read strobes decoded from state so the FIFO dout lands in the next state
    assign bus.o_cell_ptr_rd  = (state == PTR_RD);
    assign bus.o_cell_data_rd = (state == CELL_RD) || ((state == DISCARD) && disc_rd);

    function automatic logic [7:0] lane_byte(input logic [CELL_W-1:0] w, input logic [3:0] idx);
        logic [CELL_W-1:0] sh;
        sh = w << {idx, 3'b000};
        return sh[CELL_W-1 -: 8];
    endfunction

    // Frame sequencer with registered TX outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            portmap         <= '0;
            ncells          <= '0;
            plen            <= '0;
            word            <= '0;
            lane            <= '0;
            byte_cnt        <= '0;
            cell_cnt        <= '0;
            first_cell      <= 1'b0;
            ptr_pend        <= 1'b0;
            disc_rd         <= 1'b0;
            bus.tx_data_din <= '0;
            bus.tx_data_wr  <= 1'b0;
            bus.tx_ptr_din  <= '0;
            bus.tx_ptr_wr   <= 1'b0;
            bus.err_drop    <= 1'b0;
        end else begin
            bus.tx_data_wr <= 1'b0;
            bus.tx_ptr_wr  <= 1'b0;
            bus.err_drop   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.o_cell_ptr_empty && !bus.tx_ptr_full) begin
                        state <= PTR_RD;
                    end
                end

                PTR_RD: begin
                    ptr_pend   <= 1'b1;
                    first_cell <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= PTR_CAP;
                end

                PTR_CAP: begin
                    // Capture once; the state may be held while the byte FIFO is near full
                    if (ptr_pend) begin
                        portmap  <= bus.o_cell_ptr_dout[11:8];
                        ncells   <= bus.o_cell_ptr_dout[6:0];
                        ptr_pend <= 1'b0;
                    end
                    if (!bus.tx_data_afull) begin
                        state <= CELL_RD;
                    end
                end

                CELL_RD: begin
                    state <= CELL_CAP;
                end

                CELL_CAP: begin
                    word       <= bus.o_cell_data_dout;
                    first_cell <= 1'b0;
                    if (first_cell && !hdr_ok) begin
                        bus.err_drop <= 1'b1;
                        cell_cnt     <= (ncells == '0) ? '0 : ncells - NC_W'(1);
                        disc_rd      <= 1'b0;
                        state        <= DISCARD;
                    end else begin
                        if (first_cell) begin
                            plen <= hdr_plen;
                        end
                        // First byte goes out on this edge to keep the inter-cell gap at two cycles
                        bus.tx_data_wr  <= 1'b1;
                        bus.tx_data_din <= lane_byte(bus.o_cell_data_dout, start_lane);
                        lane            <= LANE_W'(start_lane) + LANE_W'(1);
                        byte_cnt        <= byte_cnt + LEN_W'(1);
                        state           <= EMIT;
                    end
                end

                EMIT: begin
                    if (byte_cnt == plen) begin
                        bus.tx_ptr_wr  <= 1'b1;
                        bus.tx_ptr_din <= tx_desc_t'{rsvd: 1'b0, portmap: portmap, plen: plen};
                        state          <= DESC;
                    end else if (lane[4]) begin
                        if (!bus.tx_data_afull) begin
                            state <= CELL_RD;
                        end
                    end else begin
                        bus.tx_data_wr  <= 1'b1;
                        bus.tx_data_din <= lane_byte(word, lane[3:0]);
                        lane            <= lane + LANE_W'(1);
                        byte_cnt        <= byte_cnt + LEN_W'(1);
                    end
                end

                DESC: begin
                    state <= IDLE;
                end

                DISCARD: begin
                    // Alternate strobe/idle cycles so each read sees a fresh word
                    if (disc_rd) begin
                        disc_rd  <= 1'b0;
                        cell_cnt <= cell_cnt - NC_W'(1);
                    end else if (cell_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        disc_rd <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_egress_unpack.sv
// Scoreboard bench for frame_egress_unpack: models the cell pointer/data FIFOs,
// pushes expected bytes, descriptors and drop pulses when a frame is queued, and
// a negedge monitor pops and compares whatever the DUT writes.
module tb_frame_egress_unpack;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    frame_egress_unpack_if bus();

    frame_egress_unpack #(.MIN_LEN(60), .MAX_LEN(1518)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [15:0]  ptr_q[$];
    logic [127:0] data_q[$];
    logic [7:0]   exp_byte[$];
    logic [15:0]  exp_desc[$];
    int exp_drop_n = 0;

    int vec = 0, err = 0, cyc = 0;
    int rx_bytes = 0, data_rd_cnt = 0, drop_seen = 0;
    int last_wr_cyc = 0, ptr_rd_cyc = 0;
    int rd_in_afull = 0, ptr_rd_in_full = 0;
    bit want_first = 1'b0, hold_afull = 1'b0, hold_full = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source FIFO models: dout valid the cycle after a read strobe
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.o_cell_ptr_dout  <= '0;
            bus.o_cell_data_dout <= '0;
            bus.o_cell_ptr_empty <= 1'b1;
        end else begin
            if (bus.o_cell_ptr_rd && ptr_q.size() != 0) bus.o_cell_ptr_dout <= ptr_q.pop_front();
            if (bus.o_cell_data_rd && data_q.size() != 0) bus.o_cell_data_dout <= data_q.pop_front();
            bus.o_cell_ptr_empty <= (ptr_q.size() == 0);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.o_cell_ptr_rd) begin
                ptr_rd_cyc = cyc;
                want_first = 1'b1;
                if (hold_full) ptr_rd_in_full++;
            end
            if (bus.o_cell_data_rd) begin
                data_rd_cnt++;
                if (hold_afull) rd_in_afull++;
            end
            if (bus.tx_data_wr) begin
                if (want_first) begin
                    chk("first_wr_latency", 32'(cyc - ptr_rd_cyc), 32'd4);
                    want_first = 1'b0;
                end
                if (exp_byte.size() == 0) begin
                    vec++; err++;
                    $display("FAIL unexpected_byte: got %h, required no write", bus.tx_data_din);
                end else begin
                    chk("tx_byte", 32'(bus.tx_data_din), 32'(exp_byte.pop_front()));
                end
                rx_bytes++;
                last_wr_cyc = cyc;
            end
            if (bus.tx_ptr_wr) begin
                chk("desc_after_last_byte", 32'(cyc - last_wr_cyc), 32'd1);
                if (exp_desc.size() == 0) begin
                    vec++; err++;
                    $display("FAIL unexpected_desc: got %h, required no write", bus.tx_ptr_din);
                end else begin
                    chk("tx_desc", 32'(bus.tx_ptr_din), 32'(exp_desc.pop_front()));
                end
            end
            if (bus.err_drop) begin
                vec++;
                if (exp_drop_n == 0) begin
                    err++;
                    $display("FAIL unexpected_err_drop: got pulse, required none");
                end else begin
                    exp_drop_n--;
                    drop_seen++;
                end
            end
        end
    end

    // Queue one frame: L = header length, nc = cell count in the pointer
    task automatic send_frame(input int L, input int nc, input logic [3:0] pm,
                              input bit good, input logic [7:0] seed);
        logic [10:0]  lv;
        logic [127:0] w;
        logic [7:0]   b;
        int k;
        lv = 11'(L);
        for (int c = 0; c < nc; c++) begin
            w = '0;
            for (int l = 0; l < 16; l++) begin
                k = c * 16 + l;
                if (k == 0)      b = {5'b10110, lv[10:8]};
                else if (k == 1) b = lv[7:0];
                else if (k < L)  b = 8'(seed + 8'(k - 2));
                else             b = 8'hEE;
                w[127 - 8*l -: 8] = b;
            end
            data_q.push_back(w);
        end
        ptr_q.push_back({4'b0000, pm, 1'b0, 7'(nc)});
        if (good) begin
            for (int i = 0; i < L - 2; i++) exp_byte.push_back(8'(seed + 8'(i)));
            exp_desc.push_back({1'b0, pm, 11'(L - 2)});
        end else begin
            exp_drop_n++;
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_byte.size() != 0 || exp_desc.size() != 0 || exp_drop_n != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (n >= 4000) begin
            err++;
            $display("FAIL %s_drain: got %0d bytes %0d descs %0d drops outstanding, required 0",
                     nm, exp_byte.size(), exp_desc.size(), exp_drop_n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ptr_rd"},   32'(bus.o_cell_ptr_rd),  32'd0);
        chk({tag, "_data_rd"},  32'(bus.o_cell_data_rd), 32'd0);
        chk({tag, "_data_din"}, 32'(bus.tx_data_din),    32'd0);
        chk({tag, "_data_wr"},  32'(bus.tx_data_wr),     32'd0);
        chk({tag, "_ptr_din"},  32'(bus.tx_ptr_din),     32'd0);
        chk({tag, "_ptr_wr"},   32'(bus.tx_ptr_wr),      32'd0);
        chk({tag, "_err_drop"}, 32'(bus.err_drop),       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, rel_cyc;
        rstn = 1'b0;
        bus.tx_data_afull = 1'b0;
        bus.tx_ptr_full   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Minimum length frame, portmap 0010 -> descriptor 16'h103C
        base = rx_bytes;
        send_frame(62, 4, 4'b0010, 1'b1, 8'h10);
        wait_drain("plen60");
        chk("plen60_count", 32'(rx_bytes - base), 32'd60);

        // L=64: last cell fully used
        base = rx_bytes;
        send_frame(64, 4, 4'b0001, 1'b1, 8'h80);
        wait_drain("plen62");
        chk("plen62_count", 32'(rx_bytes - base), 32'd62);

        // Cell count mismatch: all 5 cells read, nothing written
        base = rx_bytes; data_rd_cnt = 0; n = drop_seen;
        send_frame(62, 5, 4'b0010, 1'b0, 8'h20);
        wait_drain("ncells_bad");
        repeat (12) @(negedge clk);
        chk("drop_cell_reads", 32'(data_rd_cnt), 32'd5);
        chk("drop_no_bytes", 32'(rx_bytes - base), 32'd0);
        chk("drop_pulses", 32'(drop_seen - n), 32'd1);
        base = rx_bytes;
        send_frame(80, 5, 4'b1111, 1'b1, 8'h33);
        wait_drain("after_drop");
        chk("after_drop_count", 32'(rx_bytes - base), 32'd78);

        // Length limits just outside the accepted range
        base = rx_bytes; n = drop_seen;
        send_frame(61, 4, 4'b0100, 1'b0, 8'h40);
        send_frame(1521, 96, 4'b0100, 1'b0, 8'h41);
        wait_drain("len_limits");
        repeat (200) @(negedge clk);
        chk("len_limit_no_bytes", 32'(rx_bytes - base), 32'd0);
        chk("len_limit_drops", 32'(drop_seen - n), 32'd2);

        // Byte FIFO almost full raised mid-cell for 20 cycles
        base = rx_bytes; n = 0;
        send_frame(102, 7, 4'b0011, 1'b1, 8'h55);
        while (rx_bytes < base + 20 && n < 500) begin @(negedge clk); #1; n++; end
        chk("afull_trigger", 32'(rx_bytes - base), 32'd20);
        bus.tx_data_afull = 1'b1; hold_afull = 1'b1; rd_in_afull = 0;
        repeat (20) @(negedge clk);
        #1;
        chk("afull_stall_bytes", 32'(rx_bytes - base), 32'd30);
        chk("afull_no_cell_rd", 32'(rd_in_afull), 32'd0);
        bus.tx_data_afull = 1'b0; hold_afull = 1'b0;
        wait_drain("afull");
        chk("afull_count", 32'(rx_bytes - base), 32'd100);

        // Back-to-back max/min frames, descriptor FIFO full for 5 cycles between them
        base = rx_bytes; n = 0;
        send_frame(1520, 95, 4'b1000, 1'b1, 8'h01);
        send_frame(62, 4, 4'b0101, 1'b1, 8'h90);
        while (bus.tx_ptr_wr !== 1'b1 && n < 3000) begin @(negedge clk); #1; n++; end
        chk("max_frame_desc_seen", 32'(bus.tx_ptr_wr), 32'd1);
        bus.tx_ptr_full = 1'b1; hold_full = 1'b1; ptr_rd_in_full = 0;
        repeat (5) @(negedge clk);
        #1;
        rel_cyc = cyc;
        bus.tx_ptr_full = 1'b0; hold_full = 1'b0;
        chk("full_no_ptr_rd", 32'(ptr_rd_in_full), 32'd0);
        wait_drain("b2b");
        chk("b2b_second_after_full", 32'(ptr_rd_cyc >= rel_cyc), 32'd1);
        chk("b2b_count", 32'(rx_bytes - base), 32'd1578);

        // Reset in the middle of a frame after 30 bytes
        base = rx_bytes; n = 0;
        send_frame(102, 7, 4'b0110, 1'b1, 8'hA0);
        while (rx_bytes < base + 30 && n < 500) begin @(negedge clk); #1; n++; end
        chk("rst_trigger", 32'(rx_bytes - base), 32'd30);
        rstn = 1'b0;
        #1;
        check_zero("midrst");
        exp_byte.delete(); exp_desc.delete(); exp_drop_n = 0;
        ptr_q.delete(); data_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_more_bytes", 32'(rx_bytes - base), 32'd30);
        base = rx_bytes;
        send_frame(62, 4, 4'b0100, 1'b1, 8'hC3);
        wait_drain("post_rst");
        chk("post_rst_count", 32'(rx_bytes - base), 32'd60);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
